// File: rtl/word_mem8_pkg.sv
// Shared constants and types for the eight-word register memory that
// sits behind the 3-to-8 address decoder.
package word_mem8_pkg;

  localparam int WORDS = 8;
  localparam int ERR_W = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/word_mem8_if.sv
// Request/response bus for word_mem8: a valid/ready request channel
// addressed by one-hot word selects, and a valid/ready read-response channel.
interface word_mem8_if
  import word_mem8_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WORDS-1:0] word_sel;
  logic [WIDTH-1:0] wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req_valid, req_we, word_sel, wdata, rsp_ready,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, req_we, word_sel, wdata, rsp_ready,
    output req_ready, rsp_valid, rdata
  );

endinterface

// File: rtl/word_mem8_onehot_enc.sv
// Converts a decoder word select into a binary index and reports whether
// exactly one select line is active.
module onehot_enc
  import word_mem8_pkg::*;
(
  input  logic [WORDS-1:0] sel,
  output logic [2:0]       index,
  output logic             one_hot
);

  // Nonzero with no second bit set: clearing the lowest set bit leaves zero.
  assign one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

  always_comb begin
    index = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (sel[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/word_mem8.sv
// Eight-word register memory addressed by one-hot word selects. Writes take
// one cycle; each read yields one registered response beat. Non-one-hot
// selects are rejected and counted.
module word_mem8
  import word_mem8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  word_mem8_if.slave       bus,
  input  logic             err_clr,
  output logic             sel_err,
  output logic [ERR_W-1:0] err_count
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rdata_q;
  logic [2:0]       index;
  logic             one_hot;
  logic             accept;
  logic             bad_req;

  onehot_enc u_enc (
    .sel     (bus.word_sel),
    .index   (index),
    .one_hot (one_hot)
  );

  assign accept        = bus.req_valid && (state == IDLE);
  assign bad_req       = accept && !one_hot;
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rdata     = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && !bus.req_we) state_nx = RESP;
      RESP: if (bus.rsp_ready)         state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (accept && bus.req_we && one_hot && bus.word_sel[i]) mem[i] <= bus.wdata;
      end
    end
  end

  // A rejected read still answers, with zero, so the consumer never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (accept && !bus.req_we) begin
      rdata_q <= one_hot ? mem[index] : '0;
    end
  end

  // A new error outranks a simultaneous clear, restarting the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (bad_req) begin
      sel_err <= 1'b1;
      if (err_clr)                   err_count <= ERR_W'(1);
      else if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
    end else if (err_clr) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_word_mem8.sv
// Directed self-checking bench for word_mem8: writes, reads, backpressure,
// bad selects, error saturation/clear and asynchronous reset mid-response.
module tb_word_mem8;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic       sel_err;
  logic [3:0] err_count;
  int         compared;
  int         mismatched;

  word_mem8_if #(.WIDTH(8)) bus ();

  word_mem8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_clr   (err_clr),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] sel, input logic [7:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.word_sel  = sel;
    bus.wdata     = data;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Read with immediate consumer acceptance; checks the response beat and
  // that the port is ready again right after the handshake.
  task automatic read_word(input string tag, input logic [7:0] sel, input logic [7:0] exp);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.word_sel  = sel;
    tick();
    bus.req_valid = 1'b0;
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".rdata"}, 32'(bus.rdata), 32'(exp));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    err_clr       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.word_sel  = '0;
    bus.wdata     = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset.req_ready", 32'(bus.req_ready), 32'd1);
    check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset.rdata", 32'(bus.rdata), 32'd0);
    check("reset.sel_err", 32'(sel_err), 32'd0);
    check("reset.err_count", 32'(err_count), 32'd0);

    write_word(8'b0000_0100, 8'hA5);
    read_word("rd_w2", 8'b0000_0100, 8'hA5);
    read_word("rd_w0", 8'b0000_0001, 8'h00);
    read_word("rd_w3", 8'b0000_1000, 8'h00);

    // Back-to-back writes, one per cycle.
    write_word(8'b0000_0001, 8'h11);
    write_word(8'b0000_0010, 8'h22);
    write_word(8'b1000_0000, 8'h3C);
    read_word("rd_w0b", 8'b0000_0001, 8'h11);
    read_word("rd_w1b", 8'b0000_0010, 8'h22);

    // Backpressure on a read of word 7; a write presented meanwhile is ignored.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.word_sel  = 8'b1000_0000;
    tick();
    bus.req_we    = 1'b1;
    bus.word_sel  = 8'b0000_0001;
    bus.wdata     = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp.rdata", 32'(bus.rdata), 32'h3C);
      check("bp.req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp.ready_after", 32'(bus.req_ready), 32'd1);
    check("bp.valid_after", 32'(bus.rsp_valid), 32'd0);
    read_word("rd_w0_ignored", 8'b0000_0001, 8'h11);

    // Bad selects.
    write_word(8'b0001_0001, 8'hFF);
    check("badwr.sel_err", 32'(sel_err), 32'd1);
    check("badwr.err_count", 32'(err_count), 32'd1);
    read_word("badwr_w0", 8'b0000_0001, 8'h11);
    read_word("badwr_w4", 8'b0001_0000, 8'h00);
    read_word("badrd_zero", 8'b0000_0000, 8'h00);
    check("badrd.err_count", 32'(err_count), 32'd2);

    for (int i = 0; i < 12; i++) write_word(8'b0000_0011, 8'h55);
    check("sat.err_count_14", 32'(err_count), 32'd14);
    for (int i = 0; i < 5; i++) write_word(8'b0000_0011, 8'h55);
    check("sat.err_count_15", 32'(err_count), 32'd15);
    read_word("sat_w0", 8'b0000_0001, 8'h11);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr.sel_err", 32'(sel_err), 32'd0);
    check("clr.err_count", 32'(err_count), 32'd0);

    write_word(8'b0000_0011, 8'h55);
    write_word(8'b0000_0011, 8'h55);
    check("pre_clr.err_count", 32'(err_count), 32'd2);
    err_clr = 1'b1;
    write_word(8'b0000_0000, 8'h00);
    err_clr = 1'b0;
    check("clr_err.sel_err", 32'(sel_err), 32'd1);
    check("clr_err.err_count", 32'(err_count), 32'd1);

    // Asynchronous reset while a response is outstanding.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.word_sel  = 8'b0000_0100;
    tick();
    bus.req_valid = 1'b0;
    check("rst_mid.rsp_valid_before", 32'(bus.rsp_valid), 32'd1);
    check("rst_mid.rdata_before", 32'(bus.rdata), 32'hA5);
    rst = 1'b1;
    #2;
    check("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid.rdata", 32'(bus.rdata), 32'd0);
    check("rst_mid.sel_err", 32'(sel_err), 32'd0);
    check("rst_mid.err_count", 32'(err_count), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    read_word("post_rst_w2", 8'b0000_0100, 8'h00);
    read_word("post_rst_w7", 8'b1000_0000, 8'h00);
    read_word("post_rst_w0", 8'b0000_0001, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
